// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order instruction queue between decode and the Tomasulo
// issue stage. Decoded control words are buffered with their destination
// reservation-station channel. The head issues to that channel together with
// a ROB allocation. A head with an out-of-range channel is discarded and
// flagged.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  branch-mispredict flush (empties the queue)
//   in_valid, in_word,     decode-side write port; in_ready == !full
//   in_rs_sel, in_ready
//   rs_avail, rob_full     downstream availability
//   rs_load, rob_load      one-hot channel issue strobe and ROB allocate strobe
//   out_word               head control word (meaningful while !empty)
//   route_err              pulse when an illegally routed head is discarded
//   count, empty, full     occupancy
//   stall_cnt              saturating count of cycles the head waited
module dispatch_queue #(
  parameter int DEPTH  = 8,
  parameter int WORD_W = 64,
  parameter int NUM_RS = 5,
  parameter int SEL_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_word,
  input  logic [SEL_W-1:0]           in_rs_sel,
  output logic                       in_ready,
  input  logic [NUM_RS-1:0]          rs_avail,
  input  logic                       rob_full,
  output logic [NUM_RS-1:0]          rs_load,
  output logic                       rob_load,
  output logic [WORD_W-1:0]          out_word,
  output logic                       route_err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic [15:0]                stall_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [SEL_W:0]   RS_LIMIT = (SEL_W + 1)'(NUM_RS);

  logic [SEL_W-1:0]  sel_mem  [DEPTH];
  logic [WORD_W-1:0] word_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic [SEL_W-1:0] head_sel;
  logic             head_legal;
  logic             head_avail;
  logic             issue;
  logic             discard;
  logic             push;
  logic             pop;

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;

  assign head_sel   = sel_mem[head];
  assign out_word   = word_mem[head];
  assign head_legal = ({1'b0, head_sel} < RS_LIMIT);

  // Looked up by loop so an illegal select never indexes past rs_avail.
  always_comb begin
    head_avail = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (head_sel == SEL_W'(i)) head_avail = rs_avail[i];
    end
  end

  assign issue   = !empty && head_legal && head_avail && !rob_full && !flush && !rst;
  assign discard = !empty && !head_legal && !flush && !rst;
  assign pop     = issue || discard;
  assign push    = in_valid && !full && !flush && !rst;

  always_comb begin
    rs_load = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_load[i] = issue && (head_sel == SEL_W'(i));
    end
  end

  assign rob_load  = issue;
  assign route_err = discard;

  // Entry storage carries no reset; only pointers and counters are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[tail]  <= in_rs_sel;
      word_mem[tail] <= in_word;
    end
  end

  // Pointer / occupancy / stall counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      // stall_cnt deliberately holds across a flush.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!empty && !pop) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
